ym_phase_slot_sched: RTL and testbench



---
 rtl/ym_phase_slot_sched.sv | 147 ++++++++++++++
 tb/tb_ym_phase_slot_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_phase_slot_sched.sv
`default_nettype none
// ============================================================================
// Module   : ym_phase_slot_sched
// Purpose  : Timing master for the YM-style datapath.
//            - Divides MCLK into non-overlapping one-MCLK c1/c2 phase enables
//              (chip cycle = 2*DIV MCLK, c1 at pc==0, c2 at pc==DIV).
//            - Runs the operator slot counter (0..SLOTS-1) and frame sync.
//            - Holds one host register write and commits it as a single
//              reg_we pulse in the cycle after the c1 of slot WR_SLOT.
// Ports    : MCLK, rst_n (async, active-low)
//            c1, c2, slot, sync, frame          timing outputs
//            cpu_wr, cpu_addr, cpu_data         host write request
//            busy, ovf                          host status
//            reg_we, reg_addr, reg_data         register-file commit
//            halt (only with YM_SCHED_HALT_EN)  freezes phase/slot counting
// Option   : `define YM_SCHED_HALT_EN adds the halt input. Without it the
//            block behaves as if halt were tied low.
// Revision : 1.0 - initial release
// ============================================================================
module ym_phase_slot_sched #(
  parameter int DIV     = 3,
  parameter int SLOTS   = 18,
  parameter int SLOT_W  = 5,
  parameter int WR_SLOT = 0,
  parameter int ADDR_W  = 9
) (
  input  logic              MCLK,
  input  logic              rst_n,
`ifdef YM_SCHED_HALT_EN
  input  logic              halt,
`endif
  output logic              c1,
  output logic              c2,
  output logic [SLOT_W-1:0] slot,
  output logic              sync,
  output logic              frame,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  output logic              busy,
  output logic              ovf,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_data
);

  localparam int              PC_W      = $clog2(2 * DIV);
  localparam logic [PC_W-1:0] PC_MAX    = PC_W'(2 * DIV - 1);
  localparam logic [PC_W-1:0] PC_C2     = PC_W'(DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_WR   = SLOT_W'(WR_SLOT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic              halt_active;
  logic              run_q,   run_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;
  state_t            state_q, state_d;
  logic              ovf_q,   ovf_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        data_q,  data_d;

`ifdef YM_SCHED_HALT_EN
  assign halt_active = halt;
`else
  assign halt_active = 1'b0;
`endif

  // Phase counter and slot counter. run only comes up on the first edge after
  // reset release, so the first c1 lands in the cycle right after that edge.
  always_comb begin
    run_d  = 1'b1;
    pc_d   = pc_q;
    slot_d = slot_q;
    c1     = run_q & ~halt_active & (pc_q == '0);
    c2     = run_q & ~halt_active & (pc_q == PC_C2);
    sync   = (slot_q == SLOT_LAST);
    frame  = c2 & sync;
    if (run_q && !halt_active) begin
      pc_d = (pc_q == PC_MAX) ? '0 : pc_q + PC_W'(1);
    end
    // Slot advances on the edge that ends a c2 cycle; halt masks c2, so the
    // slot freezes along with pc.
    if (c2) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Write scheduler. A write arriving in the commit-slot c1 cycle itself is
  // still in IDLE then, so it naturally waits a full frame for the next one.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy    = (state_q != IDLE);
    reg_we  = (state_q == COMMIT);
    ovf_d   = ovf_q | (cpu_wr & busy);
    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          addr_d  = cpu_addr;
          data_d  = cpu_data;
          state_d = PEND;
        end
      end
      PEND: begin
        if (c1 && (slot_q == SLOT_WR)) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      pc_q    <= '0;
      slot_q  <= '0;
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      run_q   <= run_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign slot     = slot_q;
  assign ovf      = ovf_q;
  assign reg_addr = addr_q;
  assign reg_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ym_phase_slot_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ym_phase_slot_sched
// Purpose  : Self-checking bench for ym_phase_slot_sched. Timing outputs are
//            predicted from an "effective time" count (MCLKs since run, not
//            counting halted cycles); host writes go through a scoreboard
//            queue that a negedge monitor drains on every reg_we.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ym_phase_slot_sched;

  localparam int DIV     = 3;
  localparam int SLOTS   = 18;
  localparam int SLOT_W  = 5;
  localparam int WR_SLOT = 0;
  localparam int ADDR_W  = 9;
  localparam int PER     = 2 * DIV;
  localparam int LAT     = SLOTS * 2 * DIV + 2;

  logic              MCLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              halt_drv = 1'b0;
  logic              c1, c2, sync, frame, busy, ovf, reg_we;
  logic [SLOT_W-1:0] slot;
  logic              cpu_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_data = '0;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_data;

  ym_phase_slot_sched #(
    .DIV(DIV), .SLOTS(SLOTS), .SLOT_W(SLOT_W), .WR_SLOT(WR_SLOT), .ADDR_W(ADDR_W)
  ) dut (
    .MCLK(MCLK),
    .rst_n(rst_n),
`ifdef YM_SCHED_HALT_EN
    .halt(halt_drv),
`endif
    .c1(c1),
    .c2(c2),
    .slot(slot),
    .sync(sync),
    .frame(frame),
    .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .busy(busy),
    .ovf(ovf),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .reg_data(reg_data)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                te_c;     // effective time of the committing c1
    int                acc_cyc;  // cycle in which the write was accepted
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   te = 0;
  bit   started = 1'b0;
  bit   m_ovf = 1'b0;
  int   m_ovf_cyc = 0;
  int   prev_te = -1;
  bit   prev_halt = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int mslot(input int t);
    return ((t + DIV - 1) / PER) % SLOTS;
  endfunction

  // Advance to the next cycle: edge, update the model clock, settle.
  task automatic tick();
    @(posedge MCLK);
    cyc++;
    if (rst_n) begin
      if (!started) begin
        started = 1'b1;
        te      = 0;
      end else if (!halt_drv) begin
        te++;
      end
    end
    #1;
  endtask

  // Drive this cycle's inputs and update the reference model.
  task automatic drive(input bit wr, input int addr, input int data, input bit hlt);
    exp_t e;
    int   t;
    halt_drv = hlt;
    cpu_wr   = wr;
    cpu_addr = ADDR_W'(addr);
    cpu_data = 8'(data);
    if (wr) begin
      if (sbq.size() == 0) begin
        t = hlt ? te : te + 1;
        while (!((t % PER) == 0 && ((t / PER) % SLOTS) == WR_SLOT)) t++;
        e.addr    = ADDR_W'(addr);
        e.data    = 8'(data);
        e.te_c    = t;
        e.acc_cyc = cyc;
        sbq.push_back(e);
      end else if (!m_ovf) begin
        m_ovf     = 1'b1;
        m_ovf_cyc = cyc;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < LAT + 20 && sbq.size() > 0; i++) begin
      tick();
      drive(0, 0, 0, 0);
    end
    chk(nm, sbq.size(), 0);
  endtask

  // Monitor: compare every cycle, pop the scoreboard on each commit.
  always @(negedge MCLK) begin : monitor
    int   ph;
    int   es;
    bit   ec1, ec2;
    exp_t e;
    if (started) begin
      ph  = te % PER;
      ec1 = !halt_drv && ph == 0;
      ec2 = !halt_drv && ph == DIV;
      es  = mslot(te);
    end else begin
      ec1 = 1'b0;
      ec2 = 1'b0;
      es  = 0;
    end
    chk("c1", c1, ec1);
    chk("c2", c2, ec2);
    chk("slot", slot, es);
    chk("sync", sync, es == SLOTS - 1);
    chk("frame", frame, ec2 && es == SLOTS - 1);
    chk("busy", busy, sbq.size() > 0 && cyc > sbq[0].acc_cyc);
    chk("ovf", ovf, m_ovf && cyc > m_ovf_cyc);
    if (reg_we) begin
      if (sbq.size() == 0) begin
        chk("reg_we_spurious", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("reg_addr", reg_addr, e.addr);
        chk("reg_data", reg_data, e.data);
        chk("commit_time", prev_te, e.te_c);
        chk("commit_c1_not_halted", prev_halt, 0);
      end
    end
    prev_te   = te;
    prev_halt = halt_drv;
  end

  initial begin
    bit found;
    // Reset state
    #2;
    chk("rst_c1", c1, 0);
    chk("rst_c2", c2, 0);
    chk("rst_slot", slot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_data", reg_data, 0);
    chk("rst_ovf", ovf, 0);
    idle(3);
    rst_n = 1'b1;

    // Free run across more than one frame
    idle(2 * SLOTS * PER + 10);

    // Directed write at slot 5, then a second write while busy
    found = 1'b0;
    for (int i = 0; i < 4 * SLOTS * PER && !found; i++) begin
      tick();
      if ((te % PER) == 0 && mslot(te) == 5) found = 1'b1;
      else drive(0, 0, 0, 0);
    end
    chk("wait_slot5", found, 1);
    drive(1, 'h0A0, 'h5C, 0);
    idle(4);
    tick();
    drive(1, 'h0B0, 'h33, 0);
    drain("drain_directed");
    idle(10);

    // Reset asserted while a write is pending
    tick();
    drive(1, 'h155, 'hA7, 0);
    idle(5);
    #1;
    rst_n   = 1'b0;
    sbq.delete();
    m_ovf   = 1'b0;
    started = 1'b0;
    te      = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_reg_we", reg_we, 0);
    chk("midrst_c1", c1, 0);
    chk("midrst_c2", c2, 0);
    chk("midrst_ovf", ovf, 0);
    idle(3);
    rst_n = 1'b1;
    idle(2 * SLOTS * PER);

`ifdef YM_SCHED_HALT_EN
    // Halt for 20 MCLK at pc=2, with a write arriving during the halt
    found = 1'b0;
    for (int i = 0; i < 4 * PER && !found; i++) begin
      tick();
      if ((te % PER) == 2) found = 1'b1;
      else drive(0, 0, 0, 0);
    end
    chk("wait_pc2", found, 1);
    drive(0, 0, 0, 1);
    for (int i = 1; i < 20; i++) begin
      tick();
      drive(i == 7, 'h0C3, 'h9E, 1);
    end
    drain("drain_halt");
`endif

    // Random traffic
    for (int i = 0; i < 900; i++) begin
      tick();
`ifdef YM_SCHED_HALT_EN
      drive($urandom_range(0, 15) == 0, int'($urandom_range(0, 511)),
            int'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
`else
      drive($urandom_range(0, 15) == 0, int'($urandom_range(0, 511)),
            int'($urandom_range(0, 255)), 0);
`endif
    end
    drain("drain_random");

    // Write accepted exactly in the commit-slot c1 cycle waits a full frame
    found = 1'b0;
    for (int i = 0; i < 4 * SLOTS * PER && !found; i++) begin
      tick();
      if ((te % PER) == 0 && mslot(te) == WR_SLOT && sbq.size() == 0) found = 1'b1;
      else drive(0, 0, 0, 0);
    end
    chk("wait_wrslot", found, 1);
    drive(1, 'h1FF, 'hC3, 0);
    drain("drain_wrslot");
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
